flag_branch_resolver: RTL and testbench

- Consumer side of the zero/condition flags: holds the architectural NZCV register written by the pipeline and resolves branches in the ID stage.
- Uses NZCV for B.cond and an internal 16-bit zero reduction of the register operand for CBZ/CBNZ.
- Tracks flag-setting instructions still in flight between EX and flag writeback, and stalls ID until the flags it needs are architecturally valid.
- Sits between the ID/EX hazard logic and the PC-select mux.

---
 rtl/flag_branch_resolver_if.sv | 29 ++
 rtl/flag_branch_resolver.sv | 116 +++++++++++
 tb/tb_flag_branch_resolver.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/flag_branch_resolver_if.sv
// flag_branch_resolver_if: pipeline, branch and flag signals shared between ID/EX/WB and the resolver
interface flag_branch_resolver_if #(parameter int DATA_W = 16) ();
    logic              ex_issue;
    logic              ex_set_flags;
    logic              wb_flag_valid;
    logic [3:0]        wb_flags;
    logic              br_req;
    logic [1:0]        br_type;
    logic [3:0]        br_cond;
    logic [DATA_W-1:0] br_operand;
    logic              flush;
    logic              id_stall;
    logic              br_done;
    logic              br_taken;
    logic [3:0]        flags_q;
    logic              pend_err;
    logic [15:0]       taken_cnt;
    logic [15:0]       stall_cnt;
    modport slave (
        input  ex_issue, ex_set_flags, wb_flag_valid, wb_flags,
        input  br_req, br_type, br_cond, br_operand, flush,
        output id_stall, br_done, br_taken, flags_q, pend_err, taken_cnt, stall_cnt
    );
    modport master (
        output ex_issue, ex_set_flags, wb_flag_valid, wb_flags,
        output br_req, br_type, br_cond, br_operand, flush,
        input  id_stall, br_done, br_taken, flags_q, pend_err, taken_cnt, stall_cnt
    );
endinterface

// File: rtl/flag_branch_resolver.sv
// flag_branch_resolver: holds architectural NZCV, tracks in-flight flag writers, resolves ID-stage branches.
// Define BR_STATS_EN to build saturating taken/stall counters; otherwise those outputs read 0.
module flag_branch_resolver #(
    parameter int DATA_W = 16,
    parameter int PEND_W = 2
) (
    input logic clk,
    input logic reset,
    flag_branch_resolver_if.slave bus
);
    typedef enum logic {IDLE, WAIT} state_t;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    state_t            state_q, state_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [3:0]        nzcv_q, nzcv_d;
    logic              done_q, done_d;
    logic              taken_q, taken_d;
    logic              err_q, err_d;
    logic              set, fwd, ready, cond_ok, taken, accept, stall;
    logic [3:0]        eval_flags;
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'b0000: return z;
            4'b0001: return !z;
            4'b0010: return cy;
            4'b0011: return !cy;
            4'b0100: return n;
            4'b0101: return !n;
            4'b0110: return v;
            4'b0111: return !v;
            4'b1000: return cy & !z;
            4'b1001: return !cy | z;
            4'b1010: return n == v;
            4'b1011: return n != v;
            4'b1100: return !z & (n == v);
            4'b1101: return z | (n != v);
            default: return 1'b1;
        endcase
    endfunction
    // Flag readiness with writeback forwarding, branch outcome, acceptance and next state
    always_comb begin
        set        = bus.ex_issue & bus.ex_set_flags;
        fwd        = (pend_q == PEND_W'(1)) & bus.wb_flag_valid & !set;
        ready      = (pend_q == '0) | fwd;
        eval_flags = fwd ? bus.wb_flags : nzcv_q;
        cond_ok    = cond_eval(bus.br_cond, eval_flags);
        taken      = bus.br_type == 2'b00 ? 1'b1 :
                     bus.br_type == 2'b01 ? ~|bus.br_operand :
                     bus.br_type == 2'b10 ? |bus.br_operand : cond_ok;
        accept     = bus.br_req & !bus.flush & (ready | (state_q == IDLE & bus.br_type != 2'b11));
        stall      = bus.br_req & !accept;
        state_d    = (bus.br_req & !bus.flush & !accept) ? WAIT : IDLE;
        pend_d     = pend_q;
        err_d      = err_q;
        if (set & !bus.wb_flag_valid) begin
            pend_d = (pend_q == PEND_MAX) ? pend_q : pend_q + PEND_W'(1);
            err_d  = err_q | (pend_q == PEND_MAX);
        end else if (bus.wb_flag_valid & !set & (pend_q != '0)) begin
            pend_d = pend_q - PEND_W'(1);
        end
        nzcv_d     = bus.wb_flag_valid ? bus.wb_flags : nzcv_q;
        done_d     = accept;
        taken_d    = accept & taken;
    end
    // Resolver state, flag register, writer counter and registered branch result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            nzcv_q  <= '0;
            done_q  <= 1'b0;
            taken_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            nzcv_q  <= nzcv_d;
            done_q  <= done_d;
            taken_q <= taken_d;
            err_q   <= err_d;
        end
    end
    assign bus.id_stall = stall;
    assign bus.br_done  = done_q;
    assign bus.br_taken = taken_q;
    assign bus.flags_q  = nzcv_q;
    assign bus.pend_err = err_q;
`ifdef BR_STATS_EN
    logic [15:0] taken_cnt_q, taken_cnt_d, stall_cnt_q, stall_cnt_d;
    // Saturating event counters
    always_comb begin
        taken_cnt_d = (done_q & taken_q & ~&taken_cnt_q) ? taken_cnt_q + 16'd1 : taken_cnt_q;
        stall_cnt_d = (stall & ~&stall_cnt_q) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end
    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            taken_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
    assign bus.taken_cnt = taken_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.taken_cnt = '0;
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_flag_branch_resolver.sv
// tb_flag_branch_resolver: directed stimulus, per-cycle reference model compare, literal spot checks
module tb_flag_branch_resolver;
    localparam int PMAX = 3;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic armed = 1'b0;
    int compared = 0;
    int mismatched = 0;
    always #5 clk = ~clk;
    flag_branch_resolver_if #(.DATA_W(16)) bus ();
    flag_branch_resolver #(.DATA_W(16), .PEND_W(2)) dut (.clk(clk), .reset(reset), .bus(bus));
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        logic [7:0] base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        base = {1'b1, !z && (n == v), n == v, cy && !z, v, n, cy, z};
        return (c[3:1] == 3'b111) ? 1'b1 : base[c[3:1]] ^ c[0];
    endfunction
    int m_pend;
    logic [3:0] m_flags, m_eflags;
    logic m_err, m_done, m_taken;
    logic m_inc, m_fwd, m_ready, m_acc, m_stall, m_tk;
    logic [15:0] m_tcnt, m_scnt;
    always_comb begin
        m_inc    = bus.ex_issue & bus.ex_set_flags;
        m_fwd    = (m_pend == 1) && bus.wb_flag_valid && !m_inc;
        m_ready  = (m_pend == 0) || m_fwd;
        m_eflags = m_fwd ? bus.wb_flags : m_flags;
        m_acc    = bus.br_req && !bus.flush && (bus.br_type != 2'd3 || m_ready);
        m_stall  = bus.br_req && !m_acc;
        case (bus.br_type)
            2'd0:    m_tk = 1'b1;
            2'd1:    m_tk = bus.br_operand == 16'd0;
            2'd2:    m_tk = bus.br_operand != 16'd0;
            default: m_tk = m_cond(bus.br_cond, m_eflags);
        endcase
    end
    always @(posedge clk) begin
        if (reset) begin
            armed   <= 1'b1;
            m_pend  <= 0;
            m_flags <= 4'd0;
            m_err   <= 1'b0;
            m_done  <= 1'b0;
            m_taken <= 1'b0;
            m_tcnt  <= 16'd0;
            m_scnt  <= 16'd0;
        end else begin
            if (m_inc && !bus.wb_flag_valid) begin
                if (m_pend == PMAX) m_err <= 1'b1;
                else m_pend <= m_pend + 1;
            end else if (bus.wb_flag_valid && !m_inc && m_pend > 0) begin
                m_pend <= m_pend - 1;
            end
            if (bus.wb_flag_valid) m_flags <= bus.wb_flags;
            m_done  <= m_acc;
            m_taken <= m_acc && m_tk;
            if (m_done && m_taken && m_tcnt != 16'hFFFF) m_tcnt <= m_tcnt + 16'd1;
            if (m_stall && m_scnt != 16'hFFFF) m_scnt <= m_scnt + 16'd1;
        end
    end
    always @(negedge clk) begin
        if (armed) begin
            chk("id_stall", 16'(bus.id_stall), 16'(m_stall));
            chk("br_done", 16'(bus.br_done), 16'(m_done));
            if (m_done) chk("br_taken", 16'(bus.br_taken), 16'(m_taken));
            chk("flags_q", 16'(bus.flags_q), 16'(m_flags));
            chk("pend_err", 16'(bus.pend_err), 16'(m_err));
`ifdef BR_STATS_EN
            chk("taken_cnt", bus.taken_cnt, m_tcnt);
            chk("stall_cnt", bus.stall_cnt, m_scnt);
`else
            chk("taken_cnt", bus.taken_cnt, 16'd0);
            chk("stall_cnt", bus.stall_cnt, 16'd0);
`endif
        end
    end
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic clr();
        bus.ex_issue = 0; bus.ex_set_flags = 0; bus.wb_flag_valid = 0; bus.wb_flags = 0;
        bus.br_req = 0; bus.br_type = 0; bus.br_cond = 0; bus.br_operand = 0; bus.flush = 0;
    endtask
    task automatic br(input logic [1:0] t, input logic [3:0] c, input logic [15:0] op);
        bus.br_req = 1; bus.br_type = t; bus.br_cond = c; bus.br_operand = op;
    endtask
    task automatic nobr();
        bus.br_req = 0;
    endtask
    task automatic wb(input logic v, input logic [3:0] f);
        bus.wb_flag_valid = v; bus.wb_flags = f;
    endtask
    task automatic issue(input logic v);
        bus.ex_issue = v; bus.ex_set_flags = v;
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        clr();
        tick(); tick();
        reset = 0;
        #1;
        chk("rst_flags", 16'(bus.flags_q), 16'h0);
        chk("rst_done", 16'(bus.br_done), 16'h0);
        chk("rst_err", 16'(bus.pend_err), 16'h0);
        chk("rst_stall", 16'(bus.id_stall), 16'h0);
        // CBZ zero / nonzero
        br(2'd1, 4'd0, 16'h0000); #1;
        chk("cbz0_stall", 16'(bus.id_stall), 16'h0);
        tick(); br(2'd1, 4'd0, 16'h0100); #1;
        chk("cbz0_done", 16'(bus.br_done), 16'h1);
        chk("cbz0_taken", 16'(bus.br_taken), 16'h1);
        tick(); nobr(); #1;
        chk("cbz1_done", 16'(bus.br_done), 16'h1);
        chk("cbz1_taken", 16'(bus.br_taken), 16'h0);
        // Retire Z, then EQ / NE
        wb(1, 4'b0100); tick(); wb(0, 0); #1;
        chk("wb_flags", 16'(bus.flags_q), 16'h4);
        br(2'd3, 4'b0000, 0); #1;
        chk("eq_stall", 16'(bus.id_stall), 16'h0);
        tick(); br(2'd3, 4'b0001, 0); #1;
        chk("eq_taken", 16'(bus.br_taken), 16'h1);
        tick(); nobr(); #1;
        chk("ne_done", 16'(bus.br_done), 16'h1);
        chk("ne_taken", 16'(bus.br_taken), 16'h0);
        // In-flight writer, LT waits, forwarded writeback
        issue(1); tick(); issue(0);
        br(2'd3, 4'b1011, 0); #1;
        chk("lt_stall1", 16'(bus.id_stall), 16'h1);
        tick(); #1;
        chk("lt_stall2", 16'(bus.id_stall), 16'h1);
        tick(); wb(1, 4'b1000); #1;
        chk("lt_fwd_stall", 16'(bus.id_stall), 16'h0);
        tick(); wb(0, 0); nobr(); #1;
        chk("lt_done", 16'(bus.br_done), 16'h1);
        chk("lt_taken", 16'(bus.br_taken), 16'h1);
        chk("lt_flags", 16'(bus.flags_q), 16'h8);
        // Flush while waiting
        issue(1); tick(); issue(0);
        br(2'd3, 4'b0000, 0); tick();
        bus.flush = 1; tick();
        bus.flush = 0; nobr(); #1;
        chk("flush_done", 16'(bus.br_done), 16'h0);
        wb(1, 4'b0100); tick(); wb(0, 0); #1;
        chk("flush_nodone", 16'(bus.br_done), 16'h0);
        chk("flush_flags", 16'(bus.flags_q), 16'h4);
        br(2'd3, 4'b0000, 0); #1;
        chk("post_flush_stall", 16'(bus.id_stall), 16'h0);
        tick(); nobr(); #1;
        chk("post_flush_taken", 16'(bus.br_taken), 16'h1);
        // Counter saturation
        issue(1); tick(); tick(); tick(); tick(); issue(0); #1;
        chk("sat_err", 16'(bus.pend_err), 16'h1);
        wb(1, 4'b0000); tick(); tick(); wb(0, 0);
        br(2'd3, 4'b1110, 0); #1;
        chk("sat_pend1_stall", 16'(bus.id_stall), 16'h1);
        tick(); wb(1, 4'b0010); #1;
        chk("sat_fwd_stall", 16'(bus.id_stall), 16'h0);
        tick(); wb(0, 0); nobr(); #1;
        chk("sat_al_taken", 16'(bus.br_taken), 16'h1);
        chk("sat_err_hold", 16'(bus.pend_err), 16'h1);
        reset = 1; tick(); reset = 0; #1;
        chk("err_cleared", 16'(bus.pend_err), 16'h0);
        // Simultaneous increment and writeback at pending 1
        issue(1); tick();
        wb(1, 4'b0000); br(2'd3, 4'b0000, 0); #1;
        chk("both_stall", 16'(bus.id_stall), 16'h1);
        tick(); issue(0); wb(0, 0); #1;
        chk("both_pend1_stall", 16'(bus.id_stall), 16'h1);
        tick(); wb(1, 4'b0100); #1;
        chk("both_fwd_stall", 16'(bus.id_stall), 16'h0);
        tick(); wb(0, 0); nobr(); #1;
        chk("both_taken", 16'(bus.br_taken), 16'h1);
        // Back-to-back mixed branches and literal condition pins
        wb(1, 4'b0110); tick(); wb(0, 0);
        br(2'd3, 4'b1000, 0); tick();
        #1; chk("hi_taken", 16'(bus.br_taken), 16'h0);
        br(2'd3, 4'b1001, 0); tick();
        #1; chk("ls_taken", 16'(bus.br_taken), 16'h1);
        br(2'd2, 4'd0, 16'h0005); tick();
        #1; chk("cbnz_taken", 16'(bus.br_taken), 16'h1);
        br(2'd0, 4'd0, 0); tick();
        #1; chk("b_taken", 16'(bus.br_taken), 16'h1);
        br(2'd3, 4'b1101, 0); tick(); nobr();
        #1; chk("le_taken", 16'(bus.br_taken), 16'h1);
        // Every condition against every flag value
        for (int f = 0; f < 16; f++) begin
            wb(1, 4'(f)); tick(); wb(0, 0);
            for (int c = 0; c < 16; c++) begin
                br(2'd3, 4'(c), 0); tick();
            end
            nobr(); tick();
        end
        // Reset in the middle of a wait
        issue(1); tick(); issue(0);
        br(2'd3, 4'b0000, 0); tick();
        reset = 1; tick(); reset = 0; nobr(); #1;
        chk("rstwait_done", 16'(bus.br_done), 16'h0);
        chk("rstwait_flags", 16'(bus.flags_q), 16'h0);
        br(2'd3, 4'b0001, 0); #1;
        chk("rstwait_nostall", 16'(bus.id_stall), 16'h0);
        tick(); nobr(); #1;
        chk("rstwait_ne", 16'(bus.br_taken), 16'h1);
        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
